// File: rtl/ysyx_22050535_defines_pkg.sv
// Shared opcode constants and immediate-format encodings for the ysyx_22050535 decode stage.
package ysyx_22050535_defines;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_type_e;

endpackage

// File: rtl/ysyx_22050535_imm_gen.sv
// Pure combinational instruction decode: register fields, raw fields, immediate and legality.
module ysyx_22050535_imm_gen
  import ysyx_22050535_defines::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic [31:0]           inst,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       imm,
  output logic [6:0]            opcode,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic [2:0]            imm_type,
  output logic                  illegal
);

  imm_type_e   fmt;
  logic        known;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        high_reg;
  logic [31:0] imm32;

  assign opcode = inst[6:0];
  assign func3  = inst[14:12];
  assign func7  = inst[31:25];
  assign rs1    = inst[15 +: REG_ADDR_W];
  assign rs2    = inst[20 +: REG_ADDR_W];
  assign rd     = inst[7 +: REG_ADDR_W];

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    fmt     = IMM_R;
    known   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_STORE:        begin fmt = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BRANCH:       begin fmt = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LUI, OP_AUIPC: begin fmt = IMM_U; use_rd = 1'b1; end
      OP_JAL:          begin fmt = IMM_J; use_rd = 1'b1; end
      OP_REG: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      default:         known = 1'b0;
    endcase

    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm32 = {inst[31:12], 12'b0};
      IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Only RV32E lacks x16..x31, so the high index bit matters just there.
  assign high_reg = (use_rs1 && inst[19]) || (use_rs2 && inst[24]) || (use_rd && inst[11]);
  assign illegal  = (inst[1:0] != 2'b11) || !known || ((REG_ADDR_W < 5) && high_reg);
  assign imm      = XLEN'($signed(imm32));
  assign imm_type = fmt;

endmodule

// File: rtl/ysyx_22050535_idu_stage.sv
// Instruction decode stage: one-entry valid/ready output register plus handed-off bundle counter.
module ysyx_22050535_idu_stage
  import ysyx_22050535_defines::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       imm,
  output logic [6:0]            opcode,
  output logic [2:0]            func3,
  output logic [6:0]            func7,
  output logic [2:0]            imm_type,
  output logic                  illegal,
  output logic [CNT_W-1:0]      dec_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic [2:0]            imm_type;
    logic                  illegal;
  } bundle_t;

  bundle_t          dec;
  bundle_t          bundle_d, bundle_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign dec.pc = in_pc;

  ysyx_22050535_imm_gen #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_imm_gen (
    .inst     (in_inst),
    .rs1      (dec.rs1),
    .rs2      (dec.rs2),
    .rd       (dec.rd),
    .imm      (dec.imm),
    .opcode   (dec.opcode),
    .func3    (dec.func3),
    .func7    (dec.func7),
    .imm_type (dec.imm_type),
    .illegal  (dec.illegal)
  );

  assign in_ready = rst_n && !flush && (!valid_q || out_ready);

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    cnt_d    = cnt_q;
    if (valid_q && out_ready && !flush) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Flush wins over both a new capture and a completing handoff.
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the bundle is a handful of plain flops, not a memory, so it is reset to zero
  // NOTE: with the rest; state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = bundle_q.pc;
  assign rs1       = bundle_q.rs1;
  assign rs2       = bundle_q.rs2;
  assign rd        = bundle_q.rd;
  assign imm       = bundle_q.imm;
  assign opcode    = bundle_q.opcode;
  assign func3     = bundle_q.func3;
  assign func7     = bundle_q.func7;
  assign imm_type  = bundle_q.imm_type;
  assign illegal   = bundle_q.illegal;
  assign dec_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_22050535_idu_stage.sv
// Bench for the decode stage: an RV32E/32-bit-counter instance and an RV32I/3-bit-counter instance share stimulus.
module tb_ysyx_22050535_idu_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_out_pc, a_imm, a_dec_cnt;
  logic [3:0]  a_rs1, a_rs2, a_rd;
  logic [6:0]  a_opcode, a_func7;
  logic [2:0]  a_func3, a_imm_type;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [31:0] b_out_pc, b_imm;
  logic [2:0]  b_dec_cnt;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [6:0]  b_opcode, b_func7;
  logic [2:0]  b_func3, b_imm_type;

  ysyx_22050535_idu_stage #(.XLEN(32), .REG_ADDR_W(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_pc(a_out_pc), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
    .imm(a_imm), .opcode(a_opcode), .func3(a_func3), .func7(a_func7),
    .imm_type(a_imm_type), .illegal(a_illegal), .dec_cnt(a_dec_cnt)
  );

  ysyx_22050535_idu_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_pc(b_out_pc), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
    .imm(b_imm), .opcode(b_opcode), .func3(b_func3), .func7(b_func7),
    .imm_type(b_imm_type), .illegal(b_illegal), .dec_cnt(b_dec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc, f7;
    logic [2:0]  f3, ity;
    logic        ill4, ill5;
  } exp_t;

  int unsigned vectors;
  int unsigned miscompares;

  // Reference state: whether a bundle is held, its contents, and both counters.
  bit          m_valid;
  bit          m_zero;
  exp_t        m_b;
  int unsigned m_cnt_a;
  int unsigned m_cnt_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    int   v;
    bit   known, u1, u2, ud;
    e.pc  = pc;
    e.opc = inst[6:0];
    e.f3  = inst[14:12];
    e.f7  = inst[31:25];
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.rd  = inst[11:7];
    e.ity = 3'd0;
    v     = 0;
    known = 1; u1 = 0; u2 = 0; ud = 0;
    case (inst[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: begin
        e.ity = 3'd1; u1 = 1; ud = 1;
        v = int'(inst[30:20]) - (inst[31] ? 2048 : 0);
      end
      7'h23: begin
        e.ity = 3'd2; u1 = 1; u2 = 1;
        v = int'(inst[30:25]) * 32 + int'(inst[11:7]) - (inst[31] ? 2048 : 0);
      end
      7'h63: begin
        e.ity = 3'd3; u1 = 1; u2 = 1;
        v = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2
            - (inst[31] ? 4096 : 0);
      end
      7'h37, 7'h17: begin
        e.ity = 3'd4; ud = 1;
        v = int'(inst & 32'hFFFF_F000);
      end
      7'h6F: begin
        e.ity = 3'd5; ud = 1;
        v = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2
            - (inst[31] ? (1 << 20) : 0);
      end
      7'h33: begin u1 = 1; u2 = 1; ud = 1; end
      default: known = 0;
    endcase
    e.imm  = v;
    e.ill5 = !known;
    e.ill4 = !known || (u1 && e.rs1 >= 16) || (u2 && e.rs2 >= 16) || (ud && e.rd >= 16);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(7) != 0) w[6:0] = ops[$urandom_range(9)];
    return w;
  endfunction

  // One clock: drive at the falling edge, check in_ready, advance the model, check outputs next falling edge.
  task automatic cycle(input logic r, input logic iv, input logic [31:0] inst,
                       input logic [31:0] pc, input logic fl, input logic ordy);
    bit exp_ir;
    rst_n = r; in_valid = iv; in_inst = inst; in_pc = pc; flush = fl; out_ready = ordy;
    #1;
    exp_ir = r && !fl && (!m_valid || ordy);
    check("a_in_ready", a_in_ready, exp_ir);
    check("b_in_ready", b_in_ready, exp_ir);

    if (!r) begin
      m_valid = 0; m_zero = 1; m_cnt_a = 0; m_cnt_b = 0;
      m_b = '{default: '0};
    end else begin
      if (m_valid && ordy && !fl) begin
        m_cnt_a++;
        m_cnt_b = (m_cnt_b + 1) % 8;
      end
      if (fl) m_valid = 0;
      else if (iv && exp_ir) begin
        m_valid = 1; m_zero = 0; m_b = ref_decode(inst, pc);
      end else if (m_valid && ordy) m_valid = 0;
    end

    @(posedge clk);
    @(negedge clk);
    check("a_out_valid", a_out_valid, m_valid);
    check("b_out_valid", b_out_valid, m_valid);
    check("a_dec_cnt", a_dec_cnt, m_cnt_a);
    check("b_dec_cnt", b_dec_cnt, m_cnt_b);
    if (m_valid || m_zero) begin
      check("a_pc", a_out_pc, m_b.pc);
      check("a_imm", a_imm, m_b.imm);
      check("a_regs", {a_rs1, a_rs2, a_rd}, {m_b.rs1[3:0], m_b.rs2[3:0], m_b.rd[3:0]});
      check("a_raw", {a_opcode, a_func3, a_func7}, {m_b.opc, m_b.f3, m_b.f7});
      check("a_imm_type", a_imm_type, m_b.ity);
      check("a_illegal", a_illegal, m_zero ? 1'b0 : m_b.ill4);
      check("b_pc", b_out_pc, m_b.pc);
      check("b_imm", b_imm, m_b.imm);
      check("b_regs", {b_rs1, b_rs2, b_rd}, {m_b.rs1, m_b.rs2, m_b.rd});
      check("b_raw", {b_opcode, b_func3, b_func7}, {m_b.opc, m_b.f3, m_b.f7});
      check("b_imm_type", b_imm_type, m_b.ity);
      check("b_illegal", b_illegal, m_zero ? 1'b0 : m_b.ill5);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_valid = 0; m_zero = 1; m_cnt_a = 0; m_cnt_b = 0;
    m_b = '{default: '0};
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // Reset, with upstream offering an instruction that must be refused.
    cycle(0, 1, 32'hFFF00093, 32'h0, 0, 1);
    cycle(0, 0, 32'h0, 32'h0, 0, 0);
    check("rst_valid", a_out_valid, 1'b0);
    check("rst_illegal", a_illegal, 1'b0);
    check("rst_cnt", a_dec_cnt, 32'd0);

    // Spec example words with fixed expectations.
    cycle(1, 1, 32'hFFF00093, 32'h8000_0000, 0, 1);
    check("addi_valid", a_out_valid, 1'b1);
    check("addi_rd", a_rd, 4'd1);
    check("addi_rs1", a_rs1, 4'd0);
    check("addi_type", a_imm_type, 3'd1);
    check("addi_imm", a_imm, 32'hFFFF_FFFF);
    check("addi_illegal", a_illegal, 1'b0);
    cycle(1, 1, 32'hFE20AE23, 32'h8000_0004, 0, 1);
    check("sw_type", a_imm_type, 3'd2);
    check("sw_regs", {a_rs1, a_rs2}, {4'd1, 4'd2});
    check("sw_func3", a_func3, 3'd2);
    check("sw_imm", a_imm, 32'hFFFF_FFFC);
    cycle(1, 1, 32'h001000EF, 32'h8000_0008, 0, 1);
    check("jal_type", a_imm_type, 3'd5);
    check("jal_imm", a_imm, 32'h0000_0800);
    cycle(1, 1, 32'h00000833, 32'h8000_000C, 0, 1);
    check("e_add16_illegal", a_illegal, 1'b1);
    check("e_add16_rd", a_rd, 4'd0);
    check("i_add16_illegal", b_illegal, 1'b0);
    check("i_add16_rd", b_rd, 5'd16);
    cycle(1, 0, 32'h0, 32'h0, 0, 1);

    // Backpressure: second word waits three cycles, then goes through exactly once.
    cycle(0, 0, 32'h0, 32'h0, 0, 0);
    cycle(1, 1, 32'h00500113, 32'h100, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 32'h00A00193, 32'h104, 0, 0);
      check("stall_pc", a_out_pc, 32'h100);
    end
    cycle(1, 1, 32'h00A00193, 32'h104, 0, 1);
    check("release_pc", a_out_pc, 32'h104);
    check("release_cnt", a_dec_cnt, 32'd1);
    cycle(1, 0, 32'h0, 32'h0, 0, 1);
    check("drain_cnt", a_dec_cnt, 32'd2);
    check("drain_valid", a_out_valid, 1'b0);

    // Flush over a held bundle and a live offer; then reset mid-stream.
    cycle(1, 1, 32'h00100093, 32'h200, 0, 0);
    cycle(1, 1, 32'h00200093, 32'h204, 1, 1);
    check("flush_valid", a_out_valid, 1'b0);
    check("flush_cnt", a_dec_cnt, 32'd2);
    cycle(1, 1, 32'h00300093, 32'h208, 0, 1);
    cycle(0, 1, 32'h00400093, 32'h20C, 0, 1);
    check("midrst_valid", a_out_valid, 1'b0);
    check("midrst_cnt", a_dec_cnt, 32'd0);
    check("midrst_imm", a_imm, 32'd0);
    check("midrst_pc", a_out_pc, 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) != 0, $urandom_range(3) != 0, rand_inst(),
            $urandom & 32'hFFFF_FFFC, $urandom_range(19) == 0, $urandom_range(3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22050535_idu_stage.md
YSYX_22050535_IDU_STAGE -- requirements
Module: ysyx_22050535_idu_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate width (32 or 64).
REQ-002 SHALL have parameter REG_ADDR_W, default 4, register-index width (4 = RV32E, 5 = RV32I).
REQ-003 SHALL have parameter CNT_W, default 32, decoded-instruction counter width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  upstream instruction valid.
REQ-007 in_ready  out  1  stage can accept this cycle.
REQ-008 in_inst  in  32  raw instruction.
REQ-009 in_pc  in  XLEN  instruction PC.
REQ-010 flush  in  1  discard held/incoming instruction.
REQ-011 out_valid  out  1  decoded bundle valid.
REQ-012 out_ready  in  1  downstream accepts bundle.
REQ-013 out_pc  out  XLEN  PC of decoded instruction.
REQ-014 rs1, rs2, rd  out  REG_ADDR_W each  register indices.
REQ-015 imm  out  XLEN  sign-extended immediate.
REQ-016 opcode  out  7; func3  out  3; func7  out  7  raw fields.
REQ-017 imm_type  out  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J.
REQ-018 illegal  out  1  instruction not decodable by this configuration.
REQ-019 dec_cnt  out  CNT_W  count of bundles handed downstream.

Function
REQ-020 SHALL set in_ready = !flush && (!out_valid || out_ready), combinationally.
REQ-021 SHALL capture decode of in_inst/in_pc on a cycle with in_valid && in_ready; bundle appears with out_valid=1 the next cycle (latency 1).
REQ-022 SHALL clear out_valid next cycle when out_valid && out_ready and no new capture.
REQ-023 SHALL hold all outputs bit-stable while out_valid && !out_ready.
REQ-024 SHALL, on flush, force out_valid=0 next cycle regardless of in_valid/out_ready; flush has priority over capture and completion.
REQ-025 SHALL select imm_type by opcode: I for 0010011/0000011/1100111/1110011; S for 0100011; B for 1100011; U for 0110111/0010111; J for 1101111; R for 0110011 (imm=0).
REQ-026 SHALL build imm per RV spec: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; sign-extended from inst[31] to XLEN.
REQ-027 SHALL drive rs1/rs2/rd as low REG_ADDR_W bits of inst[19:15]/[24:20]/[11:7].
REQ-028 SHALL assert illegal if inst[1:0]!=2'b11, opcode not in REQ-025 set, or REG_ADDR_W<5 and bit 4 of any register field the format uses is 1; illegal bundles still pass the handshake.
REQ-029 SHALL increment dec_cnt by 1 on each out_valid && out_ready && !flush cycle, wrapping from 2^CNT_W-1 to 0.
REQ-030 SHALL accept back-to-back instructions at one per cycle when out_ready stays 1.

Reset
REQ-031 SHALL, when rst_n=0 at a clock edge, set out_valid=0, dec_cnt=0, all bundle outputs 0, illegal=0; in-flight bundle discarded.
REQ-032 SHALL keep in_ready=0 while rst_n=0.

Structure
REQ-033 SHALL place opcode constants and imm_type encodings in the shared ysyx_22050535_defines include.
REQ-034 SHALL isolate pure combinational decode in one sub-module ysyx_22050535_imm_gen; handshake register and counter remain in the top.

Verification
REQ-035 addi x1,x0,-1 (0xFFF00093) -> next cycle out_valid=1, rd=1, rs1=0, imm_type=1, imm=0xFFFFFFFF, illegal=0.
REQ-036 sw x2,-4(x1) (0xFE20AE23) -> imm_type=2, rs1=1, rs2=2, func3=2, imm=0xFFFFFFFC; jal x1,2048 (0x001000EF) -> imm_type=5, imm=0x00000800.
REQ-037 REG_ADDR_W=4, add x16,x0,x0 (0x00000833) -> illegal=1, rd=0; REG_ADDR_W=5 same word -> illegal=0, rd=16.
REQ-038 out_ready=0 for 3 cycles, in_valid=1 with second word -> in_ready=0, first bundle stable; release -> second bundle next cycle, no loss/duplication, dec_cnt=2.
REQ-039 flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, dec_cnt unchanged; rst_n=0 mid-stream -> all outputs 0 next cycle.
